// File: rtl/pc_gen.sv
// Program-counter generator: drives instruction-ROM address/enable under a
// valid/ready fetch handshake with trap > branch > halt > stall > transfer priority.
module pc_gen #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INC        = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_ADDR  = ADDR_WIDTH'(32'h0000_0100),
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                  clk_i_PCG,
  input  logic                  reset_i_PCG,
  input  logic                  stall_i_PCG,
  input  logic                  halt_i_PCG,
  input  logic                  branch_i_PCG,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i_PCG,
  input  logic                  trap_i_PCG,
  input  logic                  fetch_ack_i_PCG,
  output logic [ADDR_WIDTH-1:0] pc_addr_o_PCG,
  output logic [ADDR_WIDTH-1:0] pc_plus_o_PCG,
  output logic                  chip_enable_o_PCG,
  output logic                  fetch_req_o_PCG,
  output logic                  misalign_o_PCG,
  output logic [CNT_WIDTH-1:0]  fetch_cnt_o_PCG
);

  localparam logic [ADDR_WIDTH-1:0] INC_V    = ADDR_WIDTH'(INC);
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(INC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]            state;
  logic                  xfer;
  logic                  branch_unaligned;
  logic [ADDR_WIDTH-1:0] branch_target;

  assign xfer             = fetch_req_o_PCG & fetch_ack_i_PCG & ~stall_i_PCG;
  assign branch_unaligned = |(branch_addr_i_PCG & LOW_MASK);
  assign branch_target    = branch_addr_i_PCG & ~LOW_MASK;
  assign pc_plus_o_PCG    = pc_addr_o_PCG + INC_V;

  always_ff @(posedge clk_i_PCG or posedge reset_i_PCG) begin
    if (reset_i_PCG) begin
      state             <= S_IDLE;
      pc_addr_o_PCG     <= RESET_ADDR;
      chip_enable_o_PCG <= 1'b0;
      fetch_req_o_PCG   <= 1'b0;
      misalign_o_PCG    <= 1'b0;
      fetch_cnt_o_PCG   <= '0;
    end else begin
      misalign_o_PCG <= 1'b0;
      // Redirect cycles still count a completed transfer; flushing is downstream.
      if (xfer) fetch_cnt_o_PCG <= fetch_cnt_o_PCG + CNT_WIDTH'(1);

      case (state)
        S_IDLE: begin
          state             <= S_RUN;
          chip_enable_o_PCG <= 1'b1;
          fetch_req_o_PCG   <= 1'b1;
        end
        S_RUN: begin
          if (trap_i_PCG) begin
            pc_addr_o_PCG <= TRAP_ADDR;
          end else if (branch_i_PCG) begin
            pc_addr_o_PCG  <= branch_target;
            misalign_o_PCG <= branch_unaligned;
          end else if (halt_i_PCG) begin
            fetch_req_o_PCG <= 1'b0;
            state           <= S_HALT;
          end else if (!stall_i_PCG && fetch_req_o_PCG && fetch_ack_i_PCG) begin
            pc_addr_o_PCG <= pc_addr_o_PCG + INC_V;
          end
        end
        S_HALT: begin
          if (trap_i_PCG) begin
            pc_addr_o_PCG   <= TRAP_ADDR;
            fetch_req_o_PCG <= 1'b1;
            state           <= S_RUN;
          end else if (!halt_i_PCG) begin
            fetch_req_o_PCG <= 1'b1;
            state           <= S_RUN;
          end
        end
        default: begin
          state           <= S_IDLE;
          fetch_req_o_PCG <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: behavioural model checked every cycle plus
// hand-computed literal expectations; a second 8-bit instance covers PC wrap.
module tb_pc_gen;

  localparam logic [31:0] RST_A  = 32'h0;
  localparam logic [31:0] TRAP_A = 32'h100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, stall = 1'b0, halt = 1'b0, branch = 1'b0, trap = 1'b0, ack = 1'b1;
  logic [31:0] baddr = '0;
  logic [31:0] pc, pc_plus;
  logic        ce, req, mis;
  logic [15:0] cnt;

  logic       rst8 = 1'b1, branch8 = 1'b0, ack8 = 1'b0, zero8 = 1'b0;
  logic [7:0] baddr8 = '0;
  logic [7:0] pc8, plus8, cnt8;
  logic       ce8, req8, mis8;

  int vectors = 0;
  int fails   = 0;

  pc_gen dut (
    .clk_i_PCG(clk), .reset_i_PCG(rst), .stall_i_PCG(stall), .halt_i_PCG(halt),
    .branch_i_PCG(branch), .branch_addr_i_PCG(baddr), .trap_i_PCG(trap),
    .fetch_ack_i_PCG(ack), .pc_addr_o_PCG(pc), .pc_plus_o_PCG(pc_plus),
    .chip_enable_o_PCG(ce), .fetch_req_o_PCG(req), .misalign_o_PCG(mis),
    .fetch_cnt_o_PCG(cnt)
  );

  pc_gen #(.ADDR_WIDTH(8), .INC(4), .RESET_ADDR(8'h00), .TRAP_ADDR(8'h80), .CNT_WIDTH(8)) dut8 (
    .clk_i_PCG(clk), .reset_i_PCG(rst8), .stall_i_PCG(zero8), .halt_i_PCG(zero8),
    .branch_i_PCG(branch8), .branch_addr_i_PCG(baddr8), .trap_i_PCG(zero8),
    .fetch_ack_i_PCG(ack8), .pc_addr_o_PCG(pc8), .pc_plus_o_PCG(plus8),
    .chip_enable_o_PCG(ce8), .fetch_req_o_PCG(req8), .misalign_o_PCG(mis8),
    .fetch_cnt_o_PCG(cnt8)
  );

  // Model: a fetch engine that is either not yet started, running, or parked.
  logic [31:0] m_pc = RST_A;
  logic        m_ce = 1'b0, m_req = 1'b0, m_mis = 1'b0;
  logic [15:0] m_cnt = '0;
  bit          started = 0, parked = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_pc = RST_A; m_ce = 0; m_req = 0; m_mis = 0; m_cnt = 0; started = 0; parked = 0;
    end else begin
      if (m_req && ack && !stall) m_cnt = m_cnt + 16'd1;
      m_mis = 0;
      if (!started) begin
        started = 1; m_ce = 1; m_req = 1;
      end else if (parked) begin
        if (trap) begin m_pc = TRAP_A; parked = 0; m_req = 1; end
        else if (!halt) begin parked = 0; m_req = 1; end
      end else if (trap) begin
        m_pc = TRAP_A;
      end else if (branch) begin
        m_pc  = (baddr / 4) * 4;
        m_mis = (baddr % 4) != 0;
      end else if (halt) begin
        parked = 1; m_req = 0;
      end else if (!stall && ack) begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    check("m_pc", pc, m_pc);
    check("m_pc_plus", pc_plus, m_pc + 32'd4);
    check("m_ce", {31'b0, ce}, {31'b0, m_ce});
    check("m_req", {31'b0, req}, {31'b0, m_req});
    check("m_mis", {31'b0, mis}, {31'b0, m_mis});
    check("m_cnt", {16'b0, cnt}, {16'b0, m_cnt});
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pin(input string name, input logic [31:0] p, input logic r, input logic [15:0] c);
    check({name, "_pc"}, pc, p);
    check({name, "_req"}, {31'b0, req}, {31'b0, r});
    check({name, "_cnt"}, {16'b0, cnt}, {16'b0, c});
  endtask

  initial begin
    tick(2);
    pin("reset", 32'h0, 1'b0, 16'd0);
    check("reset_ce", {31'b0, ce}, 32'd0);
    rst = 0;
    tick(1);
    pin("first_edge", 32'h0, 1'b1, 16'd0);
    check("first_ce", {31'b0, ce}, 32'd1);
    tick(2);
    pin("seq_8", 32'h8, 1'b1, 16'd2);
    ack = 0;
    tick(3);
    pin("ack_low", 32'h8, 1'b1, 16'd2);
    ack = 1;
    tick(1);
    pin("ack_back", 32'hC, 1'b1, 16'd3);

    branch = 1; baddr = 32'h42;
    tick(1);
    pin("branch42", 32'h40, 1'b1, 16'd4);
    check("branch42_mis", {31'b0, mis}, 32'd1);
    branch = 0;
    tick(1);
    pin("after_branch", 32'h44, 1'b1, 16'd5);
    check("mis_one_cycle", {31'b0, mis}, 32'd0);

    stall = 1; trap = 1; branch = 1; baddr = 32'h80;
    tick(1);
    pin("trap_branch_stall", 32'h100, 1'b1, 16'd5);
    check("trap_no_mis", {31'b0, mis}, 32'd0);
    stall = 0; trap = 0; branch = 0;
    tick(1);
    pin("after_trap", 32'h104, 1'b1, 16'd6);

    branch = 1; baddr = 32'h20;
    tick(1);
    branch = 0; ack = 0; halt = 1;
    tick(1);
    ack = 1;
    tick(4);
    pin("halt5", 32'h20, 1'b0, 16'd7);
    check("halt_ce", {31'b0, ce}, 32'd1);
    branch = 1; baddr = 32'h55;
    tick(1);
    pin("halt_branch_ignored", 32'h20, 1'b0, 16'd7);
    check("halt_branch_no_mis", {31'b0, mis}, 32'd0);
    branch = 0; halt = 0;
    tick(1);
    pin("halt_release", 32'h20, 1'b1, 16'd7);
    tick(1);
    pin("resume", 32'h24, 1'b1, 16'd8);

    halt = 1;
    tick(2);
    pin("halt_again", 32'h24, 1'b0, 16'd9);
    trap = 1;
    tick(1);
    pin("trap_in_halt", 32'h100, 1'b1, 16'd9);
    trap = 0; halt = 0;
    tick(1);
    pin("post_trap_halt", 32'h104, 1'b1, 16'd10);

    halt = 1; stall = 1;
    tick(1);
    pin("halt_over_stall", 32'h104, 1'b0, 16'd10);
    halt = 0; stall = 0;
    tick(2);
    pin("run_after_hs", 32'h108, 1'b1, 16'd11);

    @(negedge clk);
    #1 rst = 1;
    #1;
    pin("async_reset", 32'h0, 1'b0, 16'd0);
    check("async_reset_ce", {31'b0, ce}, 32'd0);
    check("async_reset_mis", {31'b0, mis}, 32'd0);
    tick(1);
    rst = 0;
    tick(3);
    pin("rerun", 32'h8, 1'b1, 16'd2);

    rst8 = 0;
    tick(1);
    check("w8_start_pc", {24'b0, pc8}, 32'h00);
    branch8 = 1; baddr8 = 8'hFC;
    tick(1);
    check("w8_fc", {24'b0, pc8}, 32'hFC);
    check("w8_plus_wrap", {24'b0, plus8}, 32'h00);
    branch8 = 0; ack8 = 1;
    tick(1);
    check("w8_wrap", {24'b0, pc8}, 32'h00);
    check("w8_cnt", {24'b0, cnt8}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
